// File: rtl/decode_stage_ctrl.sv
// Decode-stage controller: owns the IF/ID pipeline register, decodes the
// immediate format of the instruction in D, and generates the F/D/E hazard
// controls for load-use hazards and the multi-cycle divider handshake.
module decode_stage_ctrl #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      InstrF,
  input  logic [XLEN-1:0]  PCF,
  input  logic [XLEN-1:0]  PCPlus4F,
  input  logic             FlushD,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             div_done,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             validD,
  output logic [2:0]       ImmSrcD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             div_start,
  output logic             div_abort,
  output logic [CNT_W-1:0] stall_cnt
);

  // Major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Immediate format selects driven to the extender.
  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_J    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  // IF/ID pipeline register and controller state.
  logic [31:0]      r_instr;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pc4;
  logic             r_valid;
  state_t           r_state;
  logic [CNT_W-1:0] r_stall_cnt;

  // Decode fields of the instruction currently in D.
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  logic [2:0] w_imm_src;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_is_div;
  logic       w_lw_stall;
  logic       w_hold;
  logic       w_start;
  logic       w_abort;

  assign w_opcode = r_instr[6:0];
  assign w_funct3 = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_funct7 = r_instr[31:25];

  // Immediate format and source-register usage from the opcode.
  always_comb begin
    w_imm_src = IMM_NONE;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR: w_imm_src = IMM_I;
      OP_STORE: begin
        w_imm_src = IMM_S;
        w_use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_imm_src = IMM_B;
        w_use_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_imm_src = IMM_J;
        w_use_rs1 = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm_src = IMM_U;
        w_use_rs1 = 1'b0;
      end
      OP_REG: w_use_rs2 = 1'b1;
      default: w_imm_src = IMM_NONE;
    endcase
  end

  // div/divu/rem/remu all share funct7=0000001 with funct3[2] set.
  assign w_is_div = (w_opcode == OP_REG) && (w_funct7 == FUNCT7_MULDIV) && w_funct3[2];

  // Load in E writing a register that the instruction in D actually reads.
  assign w_lw_stall = r_valid && ResultSrcE0 && (RdE != 5'd0) &&
                      ((w_use_rs1 && (RdE == w_rs1)) || (w_use_rs2 && (RdE == w_rs2)));

  // Hazard scheduling: load-use stalls in IDLE, divider occupancy in BUSY.
  always_comb begin
    w_hold  = 1'b0;
    w_start = 1'b0;
    w_abort = 1'b0;
    if (r_state == S_IDLE) begin
      w_hold = w_lw_stall;
      if (r_valid && w_is_div && !FlushD && !w_lw_stall) begin
        w_start = 1'b1;
        w_hold  = 1'b1;
      end
    end else begin
      // The divide sits in D until the divider reports completion; a
      // taken branch in E cancels it instead.
      w_hold  = !div_done;
      w_abort = FlushD;
    end
  end

  // Pulses are suppressed while reset is asserted so a reset never looks
  // like an abort (or start) to the divider.
  assign div_start = w_start && rst_n;
  assign div_abort = w_abort && rst_n;
  assign StallF    = w_hold;
  assign StallD    = w_hold;
  assign FlushE    = w_hold || FlushD;
  assign ImmSrcD   = w_imm_src;

  assign InstrD    = r_instr;
  assign PCD       = r_pc;
  assign PCPlus4D  = r_pc4;
  assign validD    = r_valid;
  assign stall_cnt = r_stall_cnt;

  // IF/ID register: flush beats stall, stall beats a fresh load from F.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (FlushD) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!w_hold) begin
      r_instr <= InstrF;
      r_pc    <= PCF;
      r_pc4   <= PCPlus4F;
      r_valid <= 1'b1;
    end
  end

  // Divider sequencing: IDLE -> BUSY on start, back on completion or cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) r_state <= S_BUSY;
        S_BUSY: if (FlushD || div_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of cycles the decode stage was held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
